// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the interrupt/exception priority path.
package cpu_pkg;

    localparam int unsigned N_IRQ     = 8;
    localparam int unsigned IRQ_IDX_W = 3;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_PRESENT = 1'b1
    } irq_state_e;

endpackage : cpu_pkg

// File: rtl/prio_enc_comb.sv
// Combinational lowest-index-wins priority encoder with an any-set flag.
module prio_enc_comb
    import cpu_pkg::*;
#(
    parameter int unsigned N     = N_IRQ,
    parameter int unsigned IDX_W = IRQ_IDX_W
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule : prio_enc_comb

// File: rtl/prio_encoder_irq.sv
// Sticky request collector that presents the highest-priority eligible
// request as a binary index using a valid/ack handshake.
module prio_encoder_irq
    import cpu_pkg::*;
#(
    parameter int unsigned N_REQ = N_IRQ,
    parameter int unsigned IDX_W = IRQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    output logic [N_REQ-1:0] irq_onehot,
    output logic [N_REQ-1:0] pending_o
);

    irq_state_e       state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic             irq_valid_q, irq_valid_d;
    logic [N_REQ-1:0] onehot_q, onehot_d;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             ack_acc;

    // Same-cycle requests are eligible, giving one-cycle presentation latency.
    assign elig    = (pend_q | req) & ~mask;
    assign ack_acc = irq_ack & irq_valid_q;

    prio_enc_comb #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .req_i (elig),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // Pending update: accepted ack clears the presented bit, a new request on it wins.
    always_comb begin
        clr = '0;
        if (ack_acc) begin
            clr[cur_idx_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | req;
    end

    // Presentation FSM: en only gates IDLE->PRESENT; PRESENT holds until ack.
    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        irq_valid_d = irq_valid_q;
        onehot_d    = onehot_q;
        unique case (state_q)
            IRQ_IDLE: begin
                irq_valid_d = 1'b0;
                onehot_d    = '0;
                if (en && enc_any) begin
                    state_d            = IRQ_PRESENT;
                    cur_idx_d          = enc_idx;
                    irq_valid_d        = 1'b1;
                    onehot_d           = '0;
                    onehot_d[enc_idx]  = 1'b1;
                end
            end
            IRQ_PRESENT: begin
                if (irq_ack) begin
                    state_d     = IRQ_IDLE;
                    irq_valid_d = 1'b0;
                    onehot_d    = '0;
                end
            end
            default: begin
                state_d     = IRQ_IDLE;
                irq_valid_d = 1'b0;
                onehot_d    = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IRQ_IDLE;
            pend_q      <= '0;
            cur_idx_q   <= '0;
            irq_valid_q <= 1'b0;
            onehot_q    <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cur_idx_q   <= cur_idx_d;
            irq_valid_q <= irq_valid_d;
            onehot_q    <= onehot_d;
        end
    end

    assign irq_valid  = irq_valid_q;
    assign irq_idx    = cur_idx_q;
    assign irq_onehot = onehot_q;
    assign pending_o  = pend_q;

endmodule : prio_encoder_irq

// File: tb/tb_prio_encoder_irq.sv
// Directed bench for prio_encoder_irq.
module tb_prio_encoder_irq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic [7:0] irq_onehot;
    logic [7:0] pending_o;

    int total = 0;
    int bad   = 0;

    prio_encoder_irq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .mask       (mask),
        .irq_ack    (irq_ack),
        .irq_valid  (irq_valid),
        .irq_idx    (irq_idx),
        .irq_onehot (irq_onehot),
        .pending_o  (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read and inputs changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; req = '0; mask = '0; irq_ack = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req = 8'hFF; mask = '0; irq_ack = 1'b0;
        tick(); tick();
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", irq_valid); end
        total++; if (pending_o !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h exp=00", pending_o); end
        total++; if (irq_onehot !== 8'h00) begin bad++; $display("FAIL reset_onehot got=%h exp=00", irq_onehot); end
        rst_n = 1'b1;
        tick();
        req = '0;
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL rel_valid got=%0b exp=1", irq_valid); end
        total++; if (irq_idx !== 3'd0) begin bad++; $display("FAIL rel_idx got=%0d exp=0", irq_idx); end
        total++; if (pending_o !== 8'hFF) begin bad++; $display("FAIL rel_pend got=%h exp=ff", pending_o); end
    endtask

    task automatic test_priority();
        do_reset();
        req = 8'b1010_0000;
        tick();
        req = '0;
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL pri_valid got=%0b exp=1", irq_valid); end
        total++; if (irq_idx !== 3'd5) begin bad++; $display("FAIL pri_idx got=%0d exp=5", irq_idx); end
        total++; if (irq_onehot !== 8'h20) begin bad++; $display("FAIL pri_onehot got=%h exp=20", irq_onehot); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        total++; if (pending_o !== 8'h80) begin bad++; $display("FAIL pri_pend got=%h exp=80", pending_o); end
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL pri_bubble got=%0b exp=0", irq_valid); end
        total++; if (irq_onehot !== 8'h00) begin bad++; $display("FAIL pri_bub_oh got=%h exp=00", irq_onehot); end
        tick();
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL pri_valid2 got=%0b exp=1", irq_valid); end
        total++; if (irq_idx !== 3'd7) begin bad++; $display("FAIL pri_idx2 got=%0d exp=7", irq_idx); end
        total++; if (irq_onehot !== 8'h80) begin bad++; $display("FAIL pri_onehot2 got=%h exp=80", irq_onehot); end
    endtask

    task automatic test_collision();
        do_reset();
        req = 8'h04;
        tick();
        req = '0;
        total++; if (irq_idx !== 3'd2) begin bad++; $display("FAIL col_idx got=%0d exp=2", irq_idx); end
        irq_ack = 1'b1; req = 8'h04;
        tick();
        irq_ack = 1'b0; req = '0;
        total++; if (pending_o !== 8'h04) begin bad++; $display("FAIL col_pend got=%h exp=04", pending_o); end
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL col_bubble got=%0b exp=0", irq_valid); end
        tick();
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL col_valid2 got=%0b exp=1", irq_valid); end
        total++; if (irq_idx !== 3'd2) begin bad++; $display("FAIL col_idx2 got=%0d exp=2", irq_idx); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        total++; if (pending_o !== 8'h00) begin bad++; $display("FAIL col_pend2 got=%h exp=00", pending_o); end
    endtask

    task automatic test_mask();
        do_reset();
        mask = 8'h01; req = 8'h03;
        tick();
        req = '0;
        total++; if (irq_idx !== 3'd1) begin bad++; $display("FAIL msk_idx got=%0d exp=1", irq_idx); end
        mask = 8'h02;
        tick();
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL msk_hold_v got=%0b exp=1", irq_valid); end
        total++; if (irq_idx !== 3'd1) begin bad++; $display("FAIL msk_hold_idx got=%0d exp=1", irq_idx); end
        irq_ack = 1'b1; mask = 8'h03;
        tick();
        irq_ack = 1'b0;
        total++; if (pending_o !== 8'h01) begin bad++; $display("FAIL msk_pend got=%h exp=01", pending_o); end
        tick(); tick();
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL msk_allmask got=%0b exp=0", irq_valid); end
        total++; if (pending_o !== 8'h01) begin bad++; $display("FAIL msk_keep got=%h exp=01", pending_o); end
        mask = 8'h00;
        tick();
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL msk_valid2 got=%0b exp=1", irq_valid); end
        total++; if (irq_idx !== 3'd0) begin bad++; $display("FAIL msk_idx2 got=%0d exp=0", irq_idx); end
    endtask

    task automatic test_enable_ack();
        do_reset();
        en = 1'b0; req = 8'h10;
        tick();
        req = '0;
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL en_valid got=%0b exp=0", irq_valid); end
        total++; if (pending_o !== 8'h10) begin bad++; $display("FAIL en_pend got=%h exp=10", pending_o); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        total++; if (pending_o !== 8'h10) begin bad++; $display("FAIL stray_ack_pend got=%h exp=10", pending_o); end
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL stray_ack_v got=%0b exp=0", irq_valid); end
        en = 1'b1;
        tick();
        total++; if (irq_idx !== 3'd4) begin bad++; $display("FAIL en_idx got=%0d exp=4", irq_idx); end
        total++; if (irq_onehot !== 8'h10) begin bad++; $display("FAIL en_onehot got=%h exp=10", irq_onehot); end
        en = 1'b0;
        tick();
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL en_drop got=%0b exp=1", irq_valid); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0; en = 1'b1;
        total++; if (pending_o !== 8'h00) begin bad++; $display("FAIL en_drop_pend got=%h exp=00", pending_o); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        req = 8'h08;
        tick();
        req = '0;
        total++; if (irq_idx !== 3'd3) begin bad++; $display("FAIL mid_idx got=%0d exp=3", irq_idx); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", irq_valid); end
        total++; if (pending_o !== 8'h00) begin bad++; $display("FAIL mid_pend got=%h exp=00", pending_o); end
        total++; if (irq_idx !== 3'd0) begin bad++; $display("FAIL mid_idx0 got=%0d exp=0", irq_idx); end
        tick();
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0b exp=0", irq_valid); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_collision();
        test_mask();
        test_enable_ack();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prio_encoder_irq
